aclk_controller: RTL
====================

// Module: aclk_controller
// PURPOSE
//  Main control FSM of the alarm clock. Samples keypad and buttons, sequences key entry and
//  commits entered time to alarm or current-time registers. Drives show_new_time/show_a into
//  aclk_lcd_display; drives shift/load_new_a/load_new_c/reset_count into key register and counters.
// PARAMETERS
//  TIMEOUT_SEC  10      one_second pulses of keypad inactivity before entry is abandoned (1..15)
//  NOKEY        4'd10   key code meaning "no key pressed"; codes 0-9 are digits, 11-15 ignored
// PORTS
//  clock          in   1  system clock, all logic on rising edge
//  reset          in   1  synchronous, active-high
//  one_second     in   1  one-cycle tick, once per second
//  alarm_button   in   1  level; show alarm / commit entry to alarm
//  time_button    in   1  level; commit entry to current time
//  key            in   4  keypad code; NOKEY when idle
//  show_new_time  out  1  display key buffer instead of current time
//  show_a         out  1  display alarm time
//  shift          out  1  one-cycle pulse: shift key into key buffer
//  load_new_a     out  1  one-cycle pulse: load key buffer into alarm register
//  load_new_c     out  1  one-cycle pulse: load key buffer into current-time counter
//  reset_count    out  1  one-cycle pulse with load_new_c: clear seconds counter
// BEHAVIOUR
//  - Moore FSM, outputs decoded from state register only; input sampled cycle N -> output cycle N+1.
//  - reset: state=SHOW_TIME, timeout counter=0, all outputs 0 (SHOW_TIME decodes to all 0).
//  - Digit key = key<=9. Codes 11-15 treated as NOKEY.
//  - States / outputs / transitions (listed priority order):
//    SHOW_TIME  (all 0): alarm_button->SHOW_ALARM; digit key->KEY_STORED; else stay.
//    SHOW_ALARM (show_a=1): alarm_button=0 ->SHOW_TIME; else stay.
//    KEY_STORED (shift=1, show_new_time=1): ->KEY_WAITED unconditionally.
//    KEY_WAITED (show_new_time=1): timeout->SHOW_TIME; key==NOKEY->KEY_ENTRY; else stay
//      (held key yields exactly one shift).
//    KEY_ENTRY  (show_new_time=1): alarm_button->SET_ALARM_TIME; time_button->SET_CURRENT_TIME;
//      digit key->KEY_STORED; timeout->SHOW_TIME; else stay.
//    SET_ALARM_TIME   (load_new_a=1): ->SHOW_TIME.
//    SET_CURRENT_TIME (load_new_c=1, reset_count=1): ->SHOW_TIME.
//    Unused encodings ->SHOW_TIME.
//  - Simultaneous alarm_button & time_button in KEY_ENTRY: alarm wins, no load_new_c.
//  - Button held through commit: SHOW_TIME then SHOW_ALARM if alarm_button still high.
//  - Timeout counter (4b): increments on one_second while in KEY_ENTRY or KEY_WAITED;
//    cleared in every other state (incl. KEY_STORED); timeout = (count==TIMEOUT_SEC-1 &&
//    one_second); saturates, never wraps. one_second coincident with a key: key wins.
//  - Pulse outputs are single-cycle by construction; never asserted together except
//    load_new_c with reset_count.
// CONFIGURATION
//  ACLK_KEY_TIMEOUT_EN defined: timeout counter and transitions as above.
//  Not defined: counter removed, one_second unused, timeout always 0; entry held until a
//    button commits it or reset.
// TESTING
//  1 reset high 2 cycles, random inputs -> all outputs 0, state SHOW_TIME next edge.
//  2 keys 1,8,0,3 each held 3 cycles, NOKEY gap 2 cycles -> exactly 4 shift pulses,
//    show_new_time high from first shift; time_button 1 cycle -> load_new_c=reset_count=1
//    one cycle, then show_new_time=0.
//  3 SHOW_TIME, alarm_button high 5 cycles -> show_a high 5 cycles lagging by 1; release -> 0.
//  4 (ACLK_KEY_TIMEOUT_EN) key 2 then NOKEY, 10 one_second ticks -> SHOW_TIME, no load pulse;
//    9 ticks then key 4 -> stays in entry, counter cleared.
//  5 KEY_ENTRY, alarm_button & time_button same cycle -> load_new_a one pulse, load_new_c 0.
//  6 reset asserted in KEY_WAITED with key held -> all outputs 0 next cycle, no shift.

Source files
------------

// File: rtl/aclk_controller.sv
// Alarm clock main control FSM: keypad entry sequencing and commit to alarm/current time.
// Optional keypad inactivity timeout enabled by defining ACLK_KEY_TIMEOUT_EN.
module aclk_controller #(
  parameter int unsigned TIMEOUT_SEC = 10,
  parameter logic [3:0]  NOKEY       = 4'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic       alarm_button,
  input  logic       time_button,
  input  logic [3:0] key,
  output logic       show_new_time,
  output logic       show_a,
  output logic       shift,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       reset_count
);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    SHOW_ALARM       = 3'd1,
    KEY_STORED       = 3'd2,
    KEY_WAITED       = 3'd3,
    KEY_ENTRY        = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  state_t state, next_state;
  logic   is_digit;
  logic   timeout;

  // Codes above 9 (including NOKEY) all count as "no key".
  assign is_digit = (key != NOKEY) && (key <= 4'd9);

`ifdef ACLK_KEY_TIMEOUT_EN
  logic [3:0] count;
  logic       in_entry;

  assign in_entry = (state == KEY_ENTRY) || (state == KEY_WAITED);
  assign timeout  = in_entry && one_second && (count == 4'(TIMEOUT_SEC - 1));

  always_ff @(posedge clock) begin
    if (reset || !in_entry) begin
      count <= '0;
    end else if (one_second && (count != '1)) begin
      count <= count + 4'd1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = one_second | (TIMEOUT_SEC == 0);
  assign timeout    = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= SHOW_TIME;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = SHOW_TIME;
    unique case (state)
      SHOW_TIME: begin
        if (alarm_button)  next_state = SHOW_ALARM;
        else if (is_digit) next_state = KEY_STORED;
        else               next_state = SHOW_TIME;
      end
      SHOW_ALARM:  next_state = alarm_button ? SHOW_ALARM : SHOW_TIME;
      KEY_STORED:  next_state = KEY_WAITED;
      KEY_WAITED: begin
        if (timeout)       next_state = SHOW_TIME;
        else if (!is_digit) next_state = KEY_ENTRY;
        else               next_state = KEY_WAITED;
      end
      KEY_ENTRY: begin
        if (alarm_button)     next_state = SET_ALARM_TIME;
        else if (time_button) next_state = SET_CURRENT_TIME;
        else if (is_digit)    next_state = KEY_STORED;
        else if (timeout)     next_state = SHOW_TIME;
        else                  next_state = KEY_ENTRY;
      end
      SET_ALARM_TIME:   next_state = SHOW_TIME;
      SET_CURRENT_TIME: next_state = SHOW_TIME;
      default:          next_state = SHOW_TIME;
    endcase
  end

  always_comb begin
    show_new_time = 1'b0;
    show_a        = 1'b0;
    shift         = 1'b0;
    load_new_a    = 1'b0;
    load_new_c    = 1'b0;
    reset_count   = 1'b0;
    unique case (state)
      SHOW_ALARM: show_a = 1'b1;
      KEY_STORED: begin
        shift         = 1'b1;
        show_new_time = 1'b1;
      end
      KEY_WAITED:       show_new_time = 1'b1;
      KEY_ENTRY:        show_new_time = 1'b1;
      SET_ALARM_TIME:   load_new_a = 1'b1;
      SET_CURRENT_TIME: begin
        load_new_c  = 1'b1;
        reset_count = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
